piezo_timer: RTL and testbench
==============================

# piezo_timer

Tone and cadence generator for the piezo driver. It produces the three timing signals the piezo stage muxes onto the buzzer:
- a periodic beep window for steering-enabled chirps;
- a low-frequency tone that runs only inside that window;
- a high-frequency alarm tone that runs while overspeed or low battery is flagged.

It sits directly upstream of the piezo output stage and is driven by the same status flags.

## Interface
Parameters:
- PERIOD_CNT, default 100_000_000: cadence period in clocks (2 s at 50 MHz).
- BEEP_CNT, default 12_500_000: beep window length in clocks (0.25 s). Must be less than PERIOD_CNT.
- LOW_HALF, default 25_000: half-period of the low tone in clocks (1 kHz). Must be at least 1.
- HIGH_HALF, default 6_250: half-period of the high tone in clocks (4 kHz). Must be at least 1.
- FAST_SIM, default 0: when 1, the effective period is PERIOD_CNT>>10 and the effective beep is BEEP_CNT>>10. Tone half-periods are unchanged.

Ports:
- clk, input, 1: system clock. Single clock domain.
- rst_n, input, 1: reset, asynchronous, active-low.
- en_steer, input, 1: steering enabled; gates the cadence.
- ovr_spd, input, 1: overspeed flag.
- batt_low, input, 1: low-battery flag.
- timer_2sec, output, 1: beep window, high for BEEP cycles of every PER cycles.
- timer2_ensteer, output, 1: low-tone square wave; 0 outside the window.
- timer3_battspd, output, 1: high-tone square wave; 0 when no alarm.

## Operation
- Definitions: PER and BEEP are the effective counts after FAST_SIM. per_cnt width is $clog2(PER). lo_cnt and hi_cnt widths are $clog2 of their half-period, minimum 1.
- en_act flop registers en_steer every clock. al_act flop registers (ovr_spd | batt_low).
- Period counter per_cnt:
  - cleared to 0 on any edge where en_act is 0;
  - when en_act is 1: per_cnt <= (per_cnt == PER-1) ? 0 : per_cnt+1.
- timer_2sec = en_act & (per_cnt < BEEP). It is decoded directly from flops, with no other logic.
- Low tone, using lo_cnt and lo_sq:
  - when timer_2sec is 0, lo_cnt and lo_sq are both cleared;
  - otherwise lo_cnt counts up, and when lo_cnt reaches LOW_HALF-1 it wraps to 0 and lo_sq toggles;
  - timer2_ensteer = lo_sq.
  - Because of the clear, every window starts at phase 0.
- High tone, using hi_cnt and hi_sq: same structure as the low tone, gated by al_act, with HIGH_HALF as the half-period. timer3_battspd = hi_sq.
- The alarm tone and the cadence are independent and may be active simultaneously. Priority is decided downstream.

## Timing
- Reset (asynchronous): all flops go to 0, so all three outputs are 0 immediately. Every output is 0 at reset release.
- en_steer sampled high at edge k:
  - en_act = 1 from edge k, with per_cnt still 0, so timer_2sec rises after edge k (1-cycle latency);
  - timer_2sec stays high for exactly BEEP cycles, stays low for PER-BEEP cycles, then repeats with period PER.
- Wrap: at per_cnt == PER-1 the counter returns to 0 and timer_2sec reasserts on the next cycle, with no gap cycle.
- Low tone: lo_sq first goes high LOW_HALF cycles after timer_2sec rises, then toggles every LOW_HALF cycles.
  - At window end, timer_2sec falls and lo_sq is cleared on the following edge. timer2_ensteer may therefore stay high 1 cycle past the window.
- en_steer dropped mid-window:
  - timer_2sec falls 1 cycle after the drop (en_act goes to 0);
  - per_cnt clears on the following edge;
  - reasserting en_steer restarts a full BEEP window.
- Alarm: timer3_battspd first goes high HIGH_HALF+1 cycles after the flag is sampled.
  - It returns to 0 within 2 cycles of the flag clearing.
  - A flag pulse shorter than HIGH_HALF produces no tone edge.
- Held inputs give a constant output pattern with no drift: the period is exactly PER cycles every time.

## Test plan
Bench parameters: PERIOD_CNT=100, BEEP_CNT=20, LOW_HALF=4, HIGH_HALF=2, FAST_SIM=0.
- Reset: drive rst_n low mid-tone with all inputs high -> all outputs 0 in the same cycle; after release with inputs low, all outputs stay 0.
- Cadence: en_steer high from cycle 0 -> timer_2sec high on cycles 1–20, low on cycles 21–100, high again on cycles 101–120, repeating over 10 periods.
- Low tone: inside each window timer2_ensteer reads 0000111100001111…, starting identically in every window; it is 0 from 1 cycle after the window ends.
- Alarm: batt_low pulsed high for 20 cycles with en_steer low -> timer3_battspd toggles every 2 cycles starting 3 cycles after the rise; it is 0 within 2 cycles of the fall; ovr_spd gives the same result.
- Mid-window drop: deassert en_steer when per_cnt=10 -> timer_2sec low next cycle; reassert 5 cycles later -> a fresh 20-cycle window, with timer2_ensteer phase restarted.
- FAST_SIM=1 with default counts -> timer_2sec period 97656 cycles and high time 12207 cycles.

Source files
------------

// File: rtl/piezo_timer_if.sv
// Status-flag inputs and tone/cadence outputs shared between the piezo timer
// and whatever drives it.
interface piezo_timer_if;
  logic en_steer;
  logic ovr_spd;
  logic batt_low;
  logic timer_2sec;
  logic timer2_ensteer;
  logic timer3_battspd;

  modport master (
    output en_steer, ovr_spd, batt_low,
    input  timer_2sec, timer2_ensteer, timer3_battspd
  );

  modport slave (
    input  en_steer, ovr_spd, batt_low,
    output timer_2sec, timer2_ensteer, timer3_battspd
  );
endinterface

// File: rtl/piezo_timer.sv
// Piezo cadence and tone generator: a periodic beep window, a low tone inside
// that window, and an independent high alarm tone.

// Gated square-wave generator; counter and phase clear whenever the gate drops.
module piezo_tone #(
  parameter int HALF = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic gate,
  output logic sq
);
  localparam int CW = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(HALF - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          sq_q, sq_d;

  always_comb begin
    cnt_d = '0;
    sq_d  = 1'b0;
    if (gate) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
        sq_d  = ~sq_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
        sq_d  = sq_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      sq_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sq_q  <= sq_d;
    end
  end

  assign sq = sq_q;
endmodule

module piezo_timer #(
  parameter int PERIOD_CNT = 100_000_000,
  parameter int BEEP_CNT   = 12_500_000,
  parameter int LOW_HALF   = 25_000,
  parameter int HIGH_HALF  = 6_250,
  parameter bit FAST_SIM   = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,
  piezo_timer_if.slave  bus
);
  localparam int PER  = FAST_SIM ? (PERIOD_CNT >> 10) : PERIOD_CNT;
  localparam int BEEP = FAST_SIM ? (BEEP_CNT >> 10)   : BEEP_CNT;
  localparam int PW   = (PER > 1) ? $clog2(PER) : 1;
  localparam logic [PW-1:0] PER_LAST = PW'(PER - 1);
  localparam logic [PW-1:0] BEEP_V   = PW'(BEEP);

  logic          en_act_q, en_act_d;
  logic          al_act_q, al_act_d;
  logic [PW-1:0] per_cnt_q, per_cnt_d;
  logic          win;

  always_comb begin
    en_act_d  = bus.en_steer;
    al_act_d  = bus.ovr_spd | bus.batt_low;
    per_cnt_d = '0;
    if (en_act_q)
      per_cnt_d = (per_cnt_q == PER_LAST) ? '0 : per_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_act_q  <= 1'b0;
      al_act_q  <= 1'b0;
      per_cnt_q <= '0;
    end else begin
      en_act_q  <= en_act_d;
      al_act_q  <= al_act_d;
      per_cnt_q <= per_cnt_d;
    end
  end

  // Pure decode of flops so the window edge is glitch-free downstream.
  assign win            = en_act_q & (per_cnt_q < BEEP_V);
  assign bus.timer_2sec = win;

  piezo_tone #(.HALF(LOW_HALF)) u_low (
    .clk   (clk),
    .rst_n (rst_n),
    .gate  (win),
    .sq    (bus.timer2_ensteer)
  );

  piezo_tone #(.HALF(HIGH_HALF)) u_high (
    .clk   (clk),
    .rst_n (rst_n),
    .gate  (al_act_q),
    .sq    (bus.timer3_battspd)
  );
endmodule

// File: tb/tb_piezo_timer.sv
// Bench for piezo_timer: run-length model checked every cycle, plus literal
// pins on cadence, tone phase, alarm and reset, and a FAST_SIM period measure.
module tb_piezo_timer;
  localparam int PER   = 100;
  localparam int BEEP  = 20;
  localparam int LOWH  = 4;
  localparam int HIGHH = 2;

  logic clk   = 1'b0;
  logic clk_f = 1'b0;
  logic rst_n = 1'b1;
  logic rst_f_n = 1'b0;
  always #5 clk = ~clk;
  always #1 clk_f = ~clk_f;

  piezo_timer_if m_bus ();
  piezo_timer_if f_bus ();

  piezo_timer #(.PERIOD_CNT(PER), .BEEP_CNT(BEEP), .LOW_HALF(LOWH),
                .HIGH_HALF(HIGHH), .FAST_SIM(1'b0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (m_bus)
  );

  piezo_timer #(.FAST_SIM(1'b1)) dut_fast (
    .clk   (clk_f),
    .rst_n (rst_f_n),
    .bus   (f_bus)
  );

  int checks   = 0;
  int failures = 0;
  bit fast_done = 1'b0;

  function automatic void chk(string nm, longint act, longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s at t=%0t actual=%0d expected=%0d", nm, $time, act, exp);
    end
  endfunction

  // Model: how long each enable has been continuously active, and the
  // square-wave phase that run length implies one edge later.
  bit m_en, m_al, m_lo, m_hi;
  int m_run, m_arun;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_en <= 1'b0; m_al <= 1'b0; m_lo <= 1'b0; m_hi <= 1'b0;
      m_run <= 0;   m_arun <= 0;
    end else begin
      m_lo   <= (m_en && (m_run % PER) < BEEP) ? bit'((((m_run % PER) + 1) / LOWH) % 2) : 1'b0;
      m_hi   <= m_al ? bit'(((m_arun + 1) / HIGHH) % 2) : 1'b0;
      m_run  <= m_en ? m_run + 1 : 0;
      m_arun <= m_al ? m_arun + 1 : 0;
      m_en   <= m_bus.en_steer;
      m_al   <= m_bus.ovr_spd | m_bus.batt_low;
    end
  end

  always @(negedge clk) begin
    chk("model_t2s", m_bus.timer_2sec,     longint'(m_en && (m_run % PER) < BEEP));
    chk("model_lo",  m_bus.timer2_ensteer, longint'(m_lo));
    chk("model_hi",  m_bus.timer3_battspd, longint'(m_hi));
  end

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic alarm_run(input bit use_batt);
    logic [7:0] pat;
    pat = 8'b1100_1100;  // bit n-1 = tone level on cycle n after the flag is sampled
    if (use_batt) m_bus.batt_low = 1'b1; else m_bus.ovr_spd = 1'b1;
    for (int n = 1; n <= 24; n++) begin
      cyc();
      if (n <= 8) chk(use_batt ? "batt_tone" : "ovr_tone", m_bus.timer3_battspd, longint'(pat[n-1]));
      if (n == 20) begin
        m_bus.batt_low = 1'b0;
        m_bus.ovr_spd  = 1'b0;
      end
      if (n == 22) chk("alarm_off", m_bus.timer3_battspd, 0);
    end
  endtask

  // FAST_SIM instance: measure the high time and the full period.
  initial begin
    int hi_n, per_n;
    bit fell, done, seen;
    f_bus.en_steer = 1'b0; f_bus.ovr_spd = 1'b0; f_bus.batt_low = 1'b0;
    repeat (3) @(posedge clk_f);
    #0.5 rst_f_n = 1'b1;
    f_bus.en_steer = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk_f);
      seen = f_bus.timer_2sec;
    end
    chk("fast_rise", seen, 1);
    hi_n = 0; per_n = 0; fell = 1'b0; done = 1'b0;
    while (seen && !done && per_n < 100000) begin
      if (f_bus.timer_2sec) begin
        if (fell) done = 1'b1;
        else hi_n++;
      end else fell = 1'b1;
      if (!done) begin
        per_n++;
        @(negedge clk_f);
      end
    end
    chk("fast_high", hi_n, 12207);
    chk("fast_period", per_n, 97656);
    fast_done = 1'b1;
  end

  initial begin
    int hc;
    logic [7:0] lopat;
    lopat = 8'b1111_0000;  // bit n-1 = low tone on window cycle n
    m_bus.en_steer = 1'b0; m_bus.ovr_spd = 1'b0; m_bus.batt_low = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_t2s", m_bus.timer_2sec, 0);
    chk("rst_lo",  m_bus.timer2_ensteer, 0);
    chk("rst_hi",  m_bus.timer3_battspd, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) cyc();

    // Cadence over 10 periods
    m_bus.en_steer = 1'b1;
    hc = 0;
    for (int n = 1; n <= 1000; n++) begin
      cyc();
      if (m_bus.timer_2sec) hc++;
      if (n <= 8) chk("lo_phase_w1", m_bus.timer2_ensteer, longint'(lopat[n-1]));
      if (n >= 101 && n <= 108) chk("lo_phase_w2", m_bus.timer2_ensteer, longint'(lopat[n-101]));
      case (n)
        1, 20, 101, 120, 901, 920: chk("cad_high", m_bus.timer_2sec, 1);
        21, 100, 121, 200, 921, 1000: chk("cad_low", m_bus.timer_2sec, 0);
        21: ;
        default: ;
      endcase
      if (n == 21) chk("lo_tail", m_bus.timer2_ensteer, 1);
      if (n == 22) chk("lo_cleared", m_bus.timer2_ensteer, 0);
    end
    chk("cad_high_total", hc, 200);
    m_bus.en_steer = 1'b0;
    repeat (5) cyc();

    // Alarm from each flag, then a pulse too short to toggle
    alarm_run(1'b1);
    alarm_run(1'b0);
    m_bus.batt_low = 1'b1;
    cyc();
    m_bus.batt_low = 1'b0;
    repeat (4) cyc();
    chk("short_pulse", m_bus.timer3_battspd, 0);

    // Mid-window drop and restart
    m_bus.en_steer = 1'b1;
    for (int n = 1; n <= 11; n++) cyc();
    chk("drop_pre", m_bus.timer_2sec, 1);
    m_bus.en_steer = 1'b0;
    cyc();
    chk("drop_fall", m_bus.timer_2sec, 0);
    repeat (4) cyc();
    m_bus.en_steer = 1'b1;
    hc = 0;
    for (int n = 1; n <= 40; n++) begin
      cyc();
      if (m_bus.timer_2sec) hc++;
      if (n <= 8) chk("restart_lo", m_bus.timer2_ensteer, longint'(lopat[n-1]));
    end
    chk("restart_len", hc, 20);

    // Cadence and alarm together, then async reset mid-tone
    m_bus.ovr_spd = 1'b1;
    m_bus.batt_low = 1'b1;
    repeat (30) cyc();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_t2s", m_bus.timer_2sec, 0);
    chk("arst_lo",  m_bus.timer2_ensteer, 0);
    chk("arst_hi",  m_bus.timer3_battspd, 0);
    repeat (3) @(posedge clk);
    #1;
    m_bus.en_steer = 1'b0; m_bus.ovr_spd = 1'b0; m_bus.batt_low = 1'b0;
    rst_n = 1'b1;
    repeat (10) cyc();
    chk("post_rst_t2s", m_bus.timer_2sec, 0);
    chk("post_rst_hi",  m_bus.timer3_battspd, 0);

    for (int k = 0; k < 30000 && !fast_done; k++) @(posedge clk);
    chk("fast_done", fast_done, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
